// File: rtl/cart_frame_sequencer.sv
// -----------------------------------------------------------------------------
// cart_frame_sequencer
//
// Steps the cartoonify pixel datapath (intensity -> edge detect -> mean
// average) through one 3x3 window at a time.
//
//   * A window is taken from the upstream window generator on in_valid/in_ready.
//   * Interior windows are registered onto pixelData, held for SETTLE cycles,
//     and then a single-cycle intensity_enable pulse starts the datapath.
//   * The sequencer waits for pixel_done. If it does not arrive in time, the
//     centre pixel is returned instead and timeout_err is raised.
//   * Border windows skip the datapath. Their centre pixel is returned as is.
//   * The result is offered downstream on out_valid/out_ready.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : upstream window handshake
//   in_frame          : 3x3 window, row-major, top-left pixel in the MSBs
//   in_border         : window centre lies on an image edge (bypass)
//   pixelData         : window presented to the datapath
//   intensity_enable  : one-cycle datapath start pulse
//   pixel_done        : datapath result valid (level or pulse)
//   f_pixel           : datapath result
//   out_valid/out_ready/out_pixel : downstream result handshake
//   timeout_err       : sticky; set when pixel_done did not arrive in time
//   frame_count       : completed windows, wraps modulo 2^CNT_W
//   busy              : sequencer is not idle
// -----------------------------------------------------------------------------
module cart_frame_sequencer #(
  parameter int FRAME_W = 216,
  parameter int PIX_W   = 24,
  parameter int TIMEOUT = 15,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  input  logic               in_border,
  output logic [FRAME_W-1:0] pixelData,
  output logic               intensity_enable,
  input  logic               pixel_done,
  input  logic [PIX_W-1:0]   f_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   frame_count,
  output logic               busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int         WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0] SETTLE_LD = 3'(SETTLE);
  // The START cycle counts as the first cycle of the timeout window. The
  // wait counter starts at 0 in the first WAIT cycle. Leaving WAIT when the
  // counter equals TIMEOUT-2 makes out_valid rise exactly TIMEOUT cycles
  // after the start pulse.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 2);

  logic [2:0]        state;
  logic [2:0]        settle_cnt;
  logic [WCNT_W-1:0] wait_cnt;

  // Centre pixel (index 4 of 9) of a row-major window.
  function automatic logic [PIX_W-1:0] centre_pix(input logic [FRAME_W-1:0] win);
    return win[4*PIX_W +: PIX_W];
  endfunction

  // in_ready is held low while rst is asserted, so every output reads 0
  // during reset.
  assign in_ready         = (state == S_IDLE) && !rst;
  assign intensity_enable = (state == S_START);
  assign busy             = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      pixelData   <= '0;
      out_pixel   <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        // ---- accept: capture window or bypass border centre ----
        S_IDLE: begin
          if (in_valid) begin
            if (in_border) begin
              out_pixel <= centre_pix(in_frame);
              out_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              pixelData  <= in_frame;
              settle_cnt <= SETTLE_LD;
              state      <= S_LOAD;
            end
          end
        end
        // ---- settle: pixelData held stable before the start pulse ----
        S_LOAD: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt <= 3'd1) begin
            state <= S_START;
          end
        end
        // ---- start: one-cycle intensity_enable ----
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        // ---- wait: datapath result or timeout (pixel_done wins ties) ----
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (pixel_done) begin
            out_pixel <= f_pixel;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else if (wait_cnt >= WAIT_LAST) begin
            out_pixel   <= centre_pix(pixelData);
            timeout_err <= 1'b1;
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end
        end
        // ---- output: hold result until downstream accepts ----
        S_OUT: begin
          if (out_ready) begin
            frame_count <= frame_count + 1'b1;
            out_valid   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
